fp3_sum_ctrl: RTL and testbench
===============================

// Module: fp3_sum_ctrl
// PURPOSE
//  Sequencer for a shared floating-point exponent-align / add / normalise datapath used in the radix-3 butterfly.
//  Accepts three operands x0,x1,x2 with a valid/ready handshake.
//  Forms x0 +/- x1 +/- x2 as two serial passes through one internal align+add+normalise unit.
//  Presents the result on a valid/ready output. One operation in flight; no rounding (truncation).
// PARAMETERS
//  MW  24  mantissa width; explicit leading one at bit MW-1
//  EW  8   exponent width; biased, exp==0 with mant==0 means zero
// PORTS
//  clk       in   1      clock, rising edge
//  rst_n     in   1      asynchronous active-low reset
//  in_valid  in   1      operand triple valid
//  in_ready  out  1      block can accept; high only in IDLE
//  a_s/b_s/c_s  in  1    operand signs (1 = negative)
//  a_e/b_e/c_e  in  EW   operand exponents
//  a_m/b_m/c_m  in  MW   operand mantissas
//  neg_b     in   1      subtract x1 instead of add
//  neg_c     in   1      subtract x2 instead of add
//  out_valid out  1      result valid; held until accepted
//  out_ready in   1      downstream accepts result
//  r_s       out  1      result sign
//  r_e       out  EW     result exponent
//  r_m       out  MW     result mantissa
//  r_ovf     out  1      exponent overflow occurred in either pass
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; out_valid=0; r_s=0; r_e=0; r_m=0; r_ovf=0; internal accumulator and flags cleared
//   - in_ready=1 from first clk edge after release
//  Accept: in_valid&&in_ready at edge -> capture all operands; b_s^=neg_b, c_s^=neg_c; ovf flag cleared.
//  States: IDLE->ALIGN1->ADD1->NORM1->ALIGN2->ADD2->NORM2->DONE->IDLE.
//   - Pass 1 operands: (x0,x1). Pass 2 operands: (pass-1 result, x2).
//  ALIGN (1 cycle):
//   - D=|AE-BE|; the smaller-exponent mantissa is shifted right by D and takes the larger exponent.
//   - Equal exponents: no shift.
//   - D>=MW: shifted mantissa=0.
//  ADD (1 cycle), sign-magnitude into an MW+1-bit sum:
//   - Equal signs: add magnitudes; result keeps the common sign.
//   - Unequal signs: larger minus smaller magnitude; result takes the sign of the larger.
//   - Equal magnitudes: result is zero, sign 0.
//  NORM (>=1 cycle), one action per cycle:
//   - sum==0: force exp=0, sign=0; exit.
//   - Carry bit MW set: shift right 1, exp+1; exit.
//     If exp was 2^EW-2 before the increment, set ovf.
//   - Bit MW-1 set: exit.
//   - Otherwise: shift left 1, exp-1; stay in NORM.
//     If exp==0 before the shift, flush to zero; exit.
//  Latency:
//   - accept edge to out_valid = 7 cycles when neither pass needs left shifts.
//   - Add 1 cycle per left shift.
//  DONE:
//   - out_valid=1; r_* and r_ovf held stable until out_valid&&out_ready.
//   - If ovf was set: r_e=all ones, r_m=all ones, r_s=final sign, r_ovf=1.
//   - On handshake: out_valid=0 next cycle, go to IDLE.
//   - in_ready=0 in every non-IDLE state, so in_valid is ignored there.
//  rst_n low in any state aborts the operation immediately; no partial result is emitted.
// TESTING
//  1) x0=x1=x2=1.0 (e=127, m=0x800000), neg=0 -> r_e=128, r_m=0xC00000, r_s=0, out_valid 7 cycles after accept.
//  2) x0=1.0, x1=1.0 with neg_b=1, x2=0.5 (e=126, m=0x800000) -> pass 1 gives zero; final r_e=126, r_m=0x800000, r_s=0.
//  3) x0=1.0, x1=0.75 (e=126, m=0xC00000) with neg_b=1, x2=0 -> r_e=125, r_m=0x800000, r_s=0; latency 9 cycles (2 left shifts).
//  4) x0=x1=x2: e=254, m=0xFFFFFF -> r_e=0xFF, r_m=0xFFFFFF, r_ovf=1.
//  5) Hold out_ready=0 for 5 cycles after out_valid -> r_* stable, in_ready=0, new in_valid ignored; one result on release.
//  6) Drop rst_n during ADD2 -> outputs zero at once, out_valid never rises for that op, in_ready=1 after release.

Source files
------------

// File: rtl/fp3_sum_ctrl.sv
// fp3_sum_ctrl: x0 +/- x1 +/- x2 via two serial align/add/normalise
// passes over one shared datapath, valid/ready on both sides.
module fp3_sum_ctrl #(
  parameter int MW = 24,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          a_s,
  input  logic          b_s,
  input  logic          c_s,
  input  logic [EW-1:0] a_e,
  input  logic [EW-1:0] b_e,
  input  logic [EW-1:0] c_e,
  input  logic [MW-1:0] a_m,
  input  logic [MW-1:0] b_m,
  input  logic [MW-1:0] c_m,
  input  logic          neg_b,
  input  logic          neg_c,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          r_s,
  output logic [EW-1:0] r_e,
  output logic [MW-1:0] r_m,
  output logic          r_ovf
);

  typedef enum logic [2:0] {
    IDLE, ALIGN1, ADD1, NORM1,
    ALIGN2, ADD2, NORM2, DONE
  } state_e;

  localparam logic [EW-1:0] EPRE =
    {{(EW-1){1'b1}}, 1'b0};

  state_e state_q, state_d;
  logic rdy_q;
  logic acc_s_q, acc_s_d;
  logic [EW-1:0] acc_e_q, acc_e_d;
  logic [MW:0] acc_m_q, acc_m_d;
  logic op_s_q, op_s_d;
  logic [EW-1:0] op_e_q, op_e_d;
  logic [MW-1:0] op_m_q, op_m_d;
  logic c_s_q, c_s_d;
  logic [EW-1:0] c_e_q, c_e_d;
  logic [MW-1:0] c_m_q, c_m_d;
  logic ovf_q, ovf_d;
  logic ov_q, ov_d;
  logic rs_q, rs_d;
  logic [EW-1:0] re_q, re_d;
  logic [MW-1:0] rm_q, rm_d;
  logic rovf_q, rovf_d;

  logic a_big;
  logic [EW-1:0] diff;
  logic [MW-1:0] am, small_m, sh_m;
  state_e nx;

  always_comb begin
    state_d = state_q;
    acc_s_d = acc_s_q;
    acc_e_d = acc_e_q;
    acc_m_d = acc_m_q;
    op_s_d  = op_s_q;
    op_e_d  = op_e_q;
    op_m_d  = op_m_q;
    c_s_d   = c_s_q;
    c_e_d   = c_e_q;
    c_m_d   = c_m_q;
    ovf_d   = ovf_q;
    ov_d    = ov_q;
    rs_d    = rs_q;
    re_d    = re_q;
    rm_d    = rm_q;
    rovf_d  = rovf_q;
    am      = acc_m_q[MW-1:0];
    a_big   = acc_e_q >= op_e_q;
    diff    = a_big ? acc_e_q - op_e_q
                    : op_e_q - acc_e_q;
    small_m = a_big ? op_m_q : am;
    sh_m    = (int'(diff) >= MW) ? '0
                                 : small_m >> diff;
    nx      = (state_q == NORM1) ? ALIGN2 : DONE;
    unique case (state_q)
      IDLE: begin
        if (in_valid && rdy_q) begin
          acc_s_d = a_s;
          acc_e_d = a_e;
          acc_m_d = {1'b0, a_m};
          op_s_d  = b_s ^ neg_b;
          op_e_d  = b_e;
          op_m_d  = b_m;
          c_s_d   = c_s ^ neg_c;
          c_e_d   = c_e;
          c_m_d   = c_m;
          ovf_d   = 1'b0;
          state_d = ALIGN1;
        end
      end
      ALIGN1, ALIGN2: begin
        acc_e_d = a_big ? acc_e_q : op_e_q;
        if (a_big) op_m_d = sh_m;
        else acc_m_d = {1'b0, sh_m};
        state_d = (state_q == ALIGN1) ? ADD1 : ADD2;
      end
      ADD1, ADD2: begin
        if (acc_s_q == op_s_q) begin
          acc_m_d = {1'b0, am} + {1'b0, op_m_q};
        end else if (am > op_m_q) begin
          acc_m_d = {1'b0, am - op_m_q};
        end else if (op_m_q > am) begin
          acc_m_d = {1'b0, op_m_q - am};
          acc_s_d = op_s_q;
        end else begin
          acc_m_d = '0;
          acc_s_d = 1'b0;
        end
        // second pass adds x2 to the pass-1 result
        if (state_q == ADD1) begin
          op_s_d = c_s_q;
          op_e_d = c_e_q;
          op_m_d = c_m_q;
        end
        state_d = (state_q == ADD1) ? NORM1 : NORM2;
      end
      NORM1, NORM2: begin
        if (acc_m_q == '0) begin
          acc_e_d = '0;
          acc_s_d = 1'b0;
          state_d = nx;
        end else if (acc_m_q[MW]) begin
          acc_m_d = acc_m_q >> 1;
          acc_e_d = acc_e_q + EW'(1);
          if (acc_e_q == EPRE) ovf_d = 1'b1;
          state_d = nx;
        end else if (acc_m_q[MW-1]) begin
          state_d = nx;
        end else if (acc_e_q == '0) begin
          acc_m_d = '0;
          acc_s_d = 1'b0;
          state_d = nx;
        end else begin
          acc_m_d = acc_m_q << 1;
          acc_e_d = acc_e_q - EW'(1);
        end
      end
      DONE: begin
        if (!ov_q) begin
          ov_d   = 1'b1;
          rs_d   = acc_s_q;
          rovf_d = ovf_q;
          re_d   = ovf_q ? '1 : acc_e_q;
          rm_d   = ovf_q ? '1 : acc_m_q[MW-1:0];
        end else if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      acc_s_q <= 1'b0;
      acc_e_q <= '0;
      acc_m_q <= '0;
      op_s_q  <= 1'b0;
      op_e_q  <= '0;
      op_m_q  <= '0;
      c_s_q   <= 1'b0;
      c_e_q   <= '0;
      c_m_q   <= '0;
      ovf_q   <= 1'b0;
      ov_q    <= 1'b0;
      rs_q    <= 1'b0;
      re_q    <= '0;
      rm_q    <= '0;
      rovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      acc_s_q <= acc_s_d;
      acc_e_q <= acc_e_d;
      acc_m_q <= acc_m_d;
      op_s_q  <= op_s_d;
      op_e_q  <= op_e_d;
      op_m_q  <= op_m_d;
      c_s_q   <= c_s_d;
      c_e_q   <= c_e_d;
      c_m_q   <= c_m_d;
      ovf_q   <= ovf_d;
      ov_q    <= ov_d;
      rs_q    <= rs_d;
      re_q    <= re_d;
      rm_q    <= rm_d;
      rovf_q  <= rovf_d;
    end
  end

  assign in_ready  = rdy_q && (state_q == IDLE);
  assign out_valid = ov_q;
  assign r_s       = rs_q;
  assign r_e       = re_q;
  assign r_m       = rm_q;
  assign r_ovf     = rovf_q;

endmodule

// File: tb/tb_fp3_sum_ctrl.sv
// tb_fp3_sum_ctrl: random and directed operand triples checked
// against a signed-arithmetic model of the two-pass sum.
module tb_fp3_sum_ctrl;
  localparam int MW = 24;
  localparam int EW = 8;
  localparam longint ONE = 1;

  logic clk, rst_n, in_valid, in_ready;
  logic a_s, b_s, c_s, neg_b, neg_c;
  logic [EW-1:0] a_e, b_e, c_e, r_e;
  logic [MW-1:0] a_m, b_m, c_m, r_m;
  logic out_valid, out_ready, r_s, r_ovf;

  fp3_sum_ctrl #(.MW(MW), .EW(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_s(a_s), .b_s(b_s), .c_s(c_s),
    .a_e(a_e), .b_e(b_e), .c_e(c_e),
    .a_m(a_m), .b_m(b_m), .c_m(c_m),
    .neg_b(neg_b), .neg_c(neg_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .r_s(r_s), .r_e(r_e), .r_m(r_m), .r_ovf(r_ovf)
  );

  typedef struct {
    bit s; int e; longint m; bit ov; int lat; int acc;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0, cyc = 0, nres = 0, mode = 0;
  int last_lat;
  logic last_s, last_ovf;
  logic [EW-1:0] last_e;
  logic [MW-1:0] last_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // One pass: exact signed sum of aligned magnitudes, then normalise.
  function automatic void fpass(
    input bit sa, input int ea, input longint ma,
    input bit sb, input int eb, input longint mb,
    output bit s, output int e, output longint m,
    output bit ov, output int nsh);
    longint x, y, t;
    int d;
    d = (ea > eb) ? ea - eb : eb - ea;
    e = (ea > eb) ? ea : eb;
    x = ma;
    y = mb;
    if (ea > eb) y = (d >= MW) ? 0 : (mb >> d);
    else if (eb > ea) x = (d >= MW) ? 0 : (ma >> d);
    t = (sa ? -x : x) + (sb ? -y : y);
    s = (t < 0);
    m = s ? -t : t;
    ov = 0;
    nsh = 0;
    if (m == 0) begin
      s = 0;
      e = 0;
    end else if (m >= (ONE << MW)) begin
      ov = (e == (1 << EW) - 2);
      m = m >> 1;
      e = (e + 1) % (1 << EW);
    end else begin
      while (m != 0 && m < (ONE << (MW - 1))) begin
        if (e == 0) begin
          m = 0;
          s = 0;
        end else begin
          m = m << 1;
          e--;
          nsh++;
        end
      end
    end
  endfunction

  function automatic exp_t model(
    input bit as_, input int ae_, input longint am_,
    input bit bs_, input int be_, input longint bm_,
    input bit cs_, input int ce_, input longint cm_);
    exp_t r;
    bit s1, s2, o1, o2;
    int e1, e2, n1, n2;
    longint m1, m2;
    fpass(as_, ae_, am_, bs_, be_, bm_, s1, e1, m1, o1, n1);
    fpass(s1, e1, m1, cs_, ce_, cm_, s2, e2, m2, o2, n2);
    r.s = s2;
    r.ov = o1 | o2;
    r.e = r.ov ? (1 << EW) - 1 : e2;
    r.m = r.ov ? (ONE << MW) - 1 : m2;
    r.lat = 7 + n1 + n2;
    r.acc = 0;
    return r;
  endfunction

  task automatic send(
    input logic as_, input logic [EW-1:0] ae_, input logic [MW-1:0] am_,
    input logic bs_, input logic [EW-1:0] be_, input logic [MW-1:0] bm_,
    input logic cs_, input logic [EW-1:0] ce_, input logic [MW-1:0] cm_,
    input logic nb, input logic nc);
    int w;
    exp_t x;
    w = 0;
    @(negedge clk);
    a_s = as_; a_e = ae_; a_m = am_;
    b_s = bs_; b_e = be_; b_m = bm_;
    c_s = cs_; c_e = ce_; c_m = cm_;
    neg_b = nb; neg_c = nc;
    in_valid = 1'b1;
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("accept_timeout", 64'(w), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = model(as_, int'(ae_), longint'(am_),
              bs_ ^ nb, int'(be_), longint'(bm_),
              cs_ ^ nc, int'(ce_), longint'(cm_));
    x.acc = cyc;
    q.push_back(x);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((q.size() != 0 || out_valid) && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (w >= 400) chk("drain_timeout", 64'(q.size()), 0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Compare process: checks every cycle a result is presented.
  bit was_v = 0;
  logic h_s, h_ovf;
  logic [EW-1:0] h_e;
  logic [MW-1:0] h_m;
  always @(negedge clk) begin
    if (!rst_n) begin
      was_v = 0;
    end else if (out_valid) begin
      chk("busy_in_ready", in_ready, 0);
      if (!was_v) begin
        if (q.size() == 0) begin
          chk("spurious_result", 1, 0);
        end else begin
          chk("r_s", r_s, q[0].s);
          chk("r_e", r_e, q[0].e);
          chk("r_m", r_m, q[0].m);
          chk("r_ovf", r_ovf, q[0].ov);
          chk("latency", cyc - q[0].acc, q[0].lat);
          last_s = r_s; last_e = r_e; last_m = r_m;
          last_ovf = r_ovf; last_lat = cyc - q[0].acc;
          nres++;
        end
        h_s = r_s; h_e = r_e; h_m = r_m; h_ovf = r_ovf;
        was_v = 1;
      end else begin
        chk("hold_stable", {r_s, r_e, r_m, r_ovf},
            {h_s, h_e, h_m, h_ovf});
      end
      if (out_ready) begin
        was_v = 0;
        if (q.size() != 0) void'(q.pop_front());
      end
    end else if (q.size() != 0 &&
                 cyc - q[0].acc > q[0].lat + 2) begin
      chk("result_late", cyc - q[0].acc, q[0].lat);
      void'(q.pop_front());
    end
  end

  function automatic void rnd_op(
    input int base_e, input logic [MW-1:0] base_m,
    output logic s, output logic [EW-1:0] e,
    output logic [MW-1:0] m);
    int r, ee;
    r = $urandom_range(0, 15);
    s = 1'($urandom_range(0, 1));
    m = {1'b1, 23'($urandom)};
    ee = $urandom_range(0, 254);
    if (r == 0) begin
      ee = 0;
      m = '0;
    end else if (r == 1) begin
      ee = $urandom_range(0, 4);
    end else if (r == 2) begin
      ee = $urandom_range(250, 254);
    end else if (r == 3) begin
      m = 24'($urandom);
    end else if (r <= 10) begin
      ee = base_e + $urandom_range(0, 4) - 2;
      if (ee < 0) ee = 0;
      if (ee > 254) ee = 254;
      m = base_m ^ 24'($urandom_range(0, 255));
      m[MW-1] = 1'b1;
    end
    e = 8'(ee);
  endfunction

  exp_t pin;
  int n0;
  logic xs0, xs1, xs2;
  logic [EW-1:0] xe0, xe1, xe2;
  logic [MW-1:0] xm0, xm1, xm2;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0;
    a_s = 0; b_s = 0; c_s = 0; neg_b = 0; neg_c = 0;
    a_e = 0; b_e = 0; c_e = 0; a_m = 0; b_m = 0; c_m = 0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", {r_s, r_e, r_m, r_ovf}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);

    pin = model(0, 127, 'h800000, 0, 127, 'h800000, 0, 127, 'h800000);
    chk("model_t1", {pin.e, pin.m, pin.lat}, {32'd128, 64'hC00000, 32'd7});
    send(0, 127, 'h800000, 0, 127, 'h800000, 0, 127, 'h800000, 0, 0);
    drain();
    chk("t1_res", {last_s, last_e, last_m, last_ovf}, {1'b0, 8'd128, 24'hC00000, 1'b0});
    chk("t1_lat", last_lat, 7);

    send(0, 127, 'h800000, 0, 127, 'h800000, 0, 126, 'h800000, 1, 0);
    drain();
    chk("t2_res", {last_s, last_e, last_m, last_ovf}, {1'b0, 8'd126, 24'h800000, 1'b0});

    pin = model(0, 127, 'h800000, 1, 126, 'hC00000, 0, 0, 0);
    chk("model_t3", {pin.e, pin.m, pin.lat}, {32'd125, 64'h800000, 32'd9});
    send(0, 127, 'h800000, 0, 126, 'hC00000, 0, 0, 0, 1, 0);
    drain();
    chk("t3_res", {last_s, last_e, last_m, last_ovf}, {1'b0, 8'd125, 24'h800000, 1'b0});
    chk("t3_lat", last_lat, 9);

    send(0, 254, 'hFFFFFF, 0, 254, 'hFFFFFF, 0, 254, 'hFFFFFF, 0, 0);
    drain();
    chk("t4_res", {last_e, last_m, last_ovf}, {8'hFF, 24'hFFFFFF, 1'b1});

    // Backpressure: result held, new requests ignored.
    mode = 2;
    n0 = nres;
    send(1, 130, 'h912345, 0, 128, 'hA00000, 1, 129, 'h800001, 0, 1);
    for (int w = 0; w < 100 && !out_valid; w++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a_e = 8'(100 + k);
      chk("t5_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    mode = 0;
    drain();
    repeat (15) @(negedge clk);
    chk("t5_one_result", nres - n0, 1);

    // Abort in ADD2.
    send(0, 127, 'h800000, 0, 127, 'h800000, 0, 127, 'h800000, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", {r_s, r_e, r_m, r_ovf}, 0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_in_ready", in_ready, 1);
    n0 = nres;
    repeat (12) @(negedge clk);
    chk("abort_no_result", nres - n0, 0);

    mode = 1;
    for (int i = 0; i < 300; i++) begin
      rnd_op($urandom_range(0, 254), 24'($urandom), xs0, xe0, xm0);
      rnd_op(int'(xe0), xm0, xs1, xe1, xm1);
      rnd_op(int'(xe0), xm0, xs2, xe2, xm2);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(xs0, xe0, xm0, xs1, xe1, xm1, xs2, xe2, xm2,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
